// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester-side bundle for the shared UART transmitter
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] data;
  logic [NREQ-1:0]      ack;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 tx_done;

  // Producers drive requests and bytes, and observe the scheduler's handshake.
  modport master (
    output req, data,
    input  ack, grant_id, busy, tx_done
  );

  // The scheduler consumes requests and bytes, and returns the handshake.
  modport slave (
    input  req, data,
    output ack, grant_id, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin shared 8N1 UART transmitter
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               tick,
  output logic               tx,
  uart_tx_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int SW  = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW  = $clog2(DBIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic [IDW-1:0]  last;

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = last;
    for (int k = 0; k < NREQ; k++) begin
      if (cand == IDW'(NREQ - 1)) cand = '0;
      else                        cand = cand + IDW'(1);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Frame sequencer: grant, then start/data/stop bits paced by the 16x tick.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state        <= IDLE;
      tx           <= 1'b1;
      bus.busy     <= 1'b0;
      bus.ack      <= '0;
      bus.tx_done  <= 1'b0;
      bus.grant_id <= '0;
      last         <= IDW'(NREQ - 1);
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
    end else begin
      bus.ack     <= '0;
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            shreg        <= bus.data[pick_id*DBIT +: DBIT];
            bus.ack      <= NREQ'(1) << pick_id;
            bus.grant_id <= pick_id;
            last         <= pick_id;
            s            <= '0;
            tx           <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              n     <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == SW'(15)) begin
              s     <= '0;
              shreg <= shreg >> 1;
              if (n == NW'(DBIT - 1)) begin
                tx    <= 1'b1;
                state <= STOP;
              end else begin
                n  <= n + NW'(1);
                tx <= shreg[1];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              s           <= '0;
              bus.tx_done <= 1'b1;
              bus.busy    <= 1'b0;
              state       <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for the shared UART transmitter
module tb_uart_tx_scheduler;
  logic clk_100MHz;
  logic reset;
  logic tick;
  logic tx;
  int   tick_mode;
  int   checks;
  int   errors;

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_scheduler_if #(.NREQ(4), .DBIT(8)) bus ();

  uart_tx_scheduler #(.NREQ(4), .DBIT(8), .SB_TICK(16)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .tick       (tick),
    .tx         (tx),
    .bus        (bus)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // Tick source: off, every cycle, or a divide-by-651 baud generator.
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      if (tick_mode == 1) begin
        tick = 1'b1;
        cnt  = 0;
      end else if (tick_mode == 2) begin
        if (cnt == 650) begin
          tick = 1'b1;
          cnt  = 0;
        end else begin
          tick = 1'b0;
          cnt++;
        end
      end else begin
        tick = 1'b0;
        cnt  = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b);
    exp_t e;
    e.id = id;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_100MHz);
      cyc++;
    end while (bus.ack == '0 && cyc < 400);
    chk("ack_seen", 32'(bus.ack != '0), 32'd1);
  endtask

  // Called on the ack cycle; follows the whole frame with tick every cycle.
  task automatic check_frame(input logic [3:0] set_mask, input int set_at, input int clr_at);
    exp_t       e;
    logic [7:0] got;
    logic       exp_tx;
    int         busy_cnt, done_cnt, wave_err, ack_cnt, k;
    e = exp_q.pop_front();
    chk("ack_onehot", 32'(bus.ack), 32'd1 << e.id);
    chk("grant_id", 32'(bus.grant_id), 32'(e.id));
    chk("tx_start_edge", 32'(tx), 32'd0);
    busy_cnt = int'(bus.busy);
    done_cnt = 0;
    wave_err = 0;
    ack_cnt  = 0;
    got      = '0;
    k        = 0;
    for (int j = 1; j <= 160; j++) begin
      @(negedge clk_100MHz);
      if (j == set_at) bus.req = bus.req | set_mask;
      if (j == clr_at) bus.req = bus.req & ~set_mask;
      if (j < 16) begin
        exp_tx = 1'b0;
      end else if (j < 144) begin
        k      = (j - 16) / 16;
        exp_tx = e.b[k[2:0]];
      end else begin
        exp_tx = 1'b1;
      end
      if (tx !== exp_tx) wave_err++;
      if (j >= 16 && j < 144 && (j % 16) == 8) got[k[2:0]] = tx;
      if (j < 160) begin
        busy_cnt += int'(bus.busy);
        done_cnt += int'(bus.tx_done);
        ack_cnt  += int'(bus.ack != '0);
      end
    end
    chk("frame_byte", 32'(got), 32'(e.b));
    chk("frame_waveform_errs", 32'(wave_err), 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'd160);
    chk("early_tx_done", 32'(done_cnt), 32'd0);
    chk("ack_during_frame", 32'(ack_cnt), 32'd0);
    chk("tx_done_at_end", 32'(bus.tx_done), 32'd1);
    chk("busy_drop_at_end", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int         c;
    int         cnt;
    int         dcnt;
    int         bcnt;
    logic       prev;
    logic [3:0] a;
    exp_t       e;
    checks    = 0;
    errors    = 0;
    tick_mode = 0;
    reset     = 1'b0;
    bus.req   = '0;
    bus.data  = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (3) @(negedge clk_100MHz);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_tx_done", 32'(bus.tx_done), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    reset = 1'b1;

    // Single byte A5 on requester 0.
    tick_mode = 1;
    @(negedge clk_100MHz);
    bus.data[7:0] = 8'hA5;
    bus.req       = 4'b0001;
    push(0, 8'hA5);
    wait_ack(c);
    chk("single_latency", 32'(c), 32'd1);
    bus.req = '0;
    check_frame(4'b0000, 0, 0);
    bus.data[7:0] = 8'h10;

    // Round-robin with all requests high out of reset.
    reset   = 1'b0;
    bus.req = 4'b1111;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b1;
    push(0, 8'h10);
    push(1, 8'h11);
    push(2, 8'h12);
    push(3, 8'h13);
    push(0, 8'h10);
    for (int i = 0; i < 5; i++) begin
      wait_ack(c);
      if (i > 0) chk("rr_ack_after_done", 32'(c), 32'd1);
      a = bus.ack;
      if (i < 4) begin
        bus.req = bus.req & ~a;
        check_frame(a, 1, 0);
      end else begin
        bus.req = '0;
        check_frame(4'b0000, 0, 0);
      end
    end

    // Fairness: serve 2, then 0 beats 2, then 2 beats re-raised 0.
    @(negedge clk_100MHz);
    bus.req = 4'b0100;
    push(2, 8'h12);
    wait_ack(c);
    bus.req = '0;
    check_frame(4'b0000, 0, 0);
    bus.req = 4'b0101;
    push(0, 8'h10);
    push(2, 8'h12);
    wait_ack(c);
    bus.req = bus.req & ~bus.ack;
    check_frame(4'b0001, 1, 0);
    wait_ack(c);
    bus.req = '0;
    check_frame(4'b0000, 0, 0);

    // Withdrawal: requester 1 pulses for 3 cycles while busy.
    bus.req = 4'b1000;
    push(3, 8'h13);
    wait_ack(c);
    bus.req = '0;
    check_frame(4'b0010, 20, 23);
    bus.req = 4'b0001;
    push(0, 8'h10);
    wait_ack(c);
    chk("withdraw_next_latency", 32'(c), 32'd1);
    bus.req = '0;
    check_frame(4'b0000, 0, 0);

    // Reset during data bit 4.
    bus.req = 4'b0100;
    push(2, 8'h12);
    wait_ack(c);
    bus.req = '0;
    e = exp_q.pop_front();
    chk("abort_grant_id", 32'(bus.grant_id), 32'(e.id));
    repeat (88) @(negedge clk_100MHz);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk_100MHz);
    reset = 1'b1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_tx_done", 32'(bus.tx_done), 32'd0);
    chk("abort_grant_reset", 32'(bus.grant_id), 32'd0);
    dcnt = 0;
    bcnt = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk_100MHz);
      dcnt += int'(bus.tx_done);
      bcnt += int'(bus.busy);
    end
    chk("abort_no_tx_done", 32'(dcnt), 32'd0);
    chk("abort_stays_idle", 32'(bcnt), 32'd0);
    bus.req = 4'b1111;
    push(0, 8'h10);
    wait_ack(c);
    bus.req = '0;
    check_frame(4'b0000, 0, 0);

    // Real baud rate: 651-clock tick, byte 55 gives a transition at every bit.
    tick_mode     = 2;
    bus.data[7:0] = 8'h55;
    @(negedge clk_100MHz);
    bus.req = 4'b0001;
    push(0, 8'h55);
    wait_ack(c);
    bus.req = '0;
    e = exp_q.pop_front();
    chk("baud_grant_id", 32'(bus.grant_id), 32'(e.id));
    cnt = 1;
    while (tx === 1'b0 && cnt < 20000) begin
      @(negedge clk_100MHz);
      cnt++;
    end
    chk("baud_start_len_ok", 32'(cnt >= 10416 && cnt <= 10416 + 651), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("baud_bit_value", 32'(tx), 32'(e.b[k]));
      prev = tx;
      cnt  = 0;
      while (tx === prev && cnt < 20000) begin
        @(negedge clk_100MHz);
        cnt++;
      end
      chk("baud_bit_len_ok", 32'(cnt >= 10415 && cnt <= 10417), 32'd1);
    end
    reset = 1'b0;
    @(negedge clk_100MHz);
    reset     = 1'b1;
    tick_mode = 1;
    chk("final_tx_idle", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one 8N1 UART transmit line among several requesters, with round-robin arbitration. It consumes the 16x oversampling `tick` from the baud-rate generator (M = 651 at 100 MHz gives 9600 baud × 16), sequences start, data and stop bits, and hands back a per-requester acknowledge. It sits between the game-logic byte producers and the board's UART TX pin.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: ticks in the stop bit (16 = 1 stop bit).
- `clk_100MHz`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low; `reset == 0` at a rising edge resets the block.
- `tick`  in  1  one-cycle oversample strobe from the baud-rate generator.
- `req`  in  NREQ  per-requester transmit request, level-sensitive.
- `data`  in  NREQ*DBIT  flattened bytes; requester i occupies bits [i*DBIT +: DBIT].
- `ack`  out  NREQ  one-cycle pulse; the byte of requester i was latched.
- `grant_id`  out  clog2(NREQ)  index of the requester currently or last served.
- `busy`  out  1  frame in progress.
- `tx`  out  1  serial line, idle high.
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
- FSM states:
  - `IDLE`: `tx = 1`, `busy = 0`. If any `req` bit is high, select the winner, latch its byte into the shift register, pulse its `ack`, load `grant_id`, clear the tick counter `s`, and go to `START`.
  - `START`: `tx = 0`. When `tick && s == 15`, clear `s` and bit counter `n`, then go to `DATA`; otherwise `s++` on each `tick`.
  - `DATA`: `tx = shreg[0]`, LSB first. When `tick && s == 15`, shift right and clear `s`. If `n == DBIT-1`, go to `STOP`; else `n++`.
  - `STOP`: `tx = 1`. When `tick && s == SB_TICK-1`, pulse `tx_done` and go to `IDLE`.
- Arbitration is round-robin:
  - Pointer `last` holds the most recently granted index.
  - Search order is `last+1, last+2, …` modulo NREQ; the first requester with `req` high wins.
  - `last` updates only on a grant.
  - Only the winner sees `ack`. Losers keep `req` high and wait.
- Requester contract:
  - Hold `data` stable while `req` is high.
  - Drop `req` no later than the cycle after `ack`.
  - `req` held high after that is treated as a new request.
  - Dropping `req` before `ack` withdraws the request silently.
- `tick` has no effect in `IDLE`. Ticks arriving in the cycle the FSM leaves `IDLE` are ignored.
- Counter widths: `s` is 4 bits wide, or wider if `SB_TICK > 16`; `n` is clog2(DBIT) bits. Neither counter ever wraps past its terminal value.
- Reset, including mid-frame:
  - Next cycle: state `IDLE`, `tx = 1`, `busy = 0`, `ack = 0`, `tx_done = 0`, `grant_id = 0`, `last = NREQ-1` (so requester 0 has first priority), `s = n = shreg = 0`.
  - An aborted frame produces no `tx_done`.

## Timing
- All outputs are registered.
- Request to line:
  - `req` is sampled high in an `IDLE` cycle T.
  - At cycle T+1: `ack` and `busy` go high and `tx` falls.
  - `ack` is low again at T+2.
- Bit length is exactly 16 ticks, except the start bit, which lasts 16 ticks counted from the first tick after T+1.
- Frame length: (16 + 16·DBIT + SB_TICK) ticks = 160 ticks with defaults.
- At completion, `tx_done` and the `IDLE` state appear in the same cycle, and `busy` drops in that cycle.
- The earliest next `ack` comes one cycle after `tx_done`. Back-to-back frames therefore have at least one idle-high clock between stop bit and start bit.
- A `tick` coincident with `reset == 0` is discarded.

## Test plan
- **Single byte, 8'hA5 on requester 0, `tick` every cycle.**
  - `ack[0]` at T+1.
  - `tx` sequence: 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 (LSB first), 16 cycles each, then 1 for 16 cycles.
  - `tx_done` at T+161; `busy` high for exactly 160 cycles.
- **Round-robin, all four `req` high from reset, bytes 8'h10/11/12/13.**
  - Grant order is 0,1,2,3,0.
  - Each `ack` arrives one cycle after the previous `tx_done`.
- **Fairness.**
  - Requester 2 served last; `req` = 4'b0101 → requester 0 granted next, not 2.
  - Then, with `req[2]` still high and `req[0]` re-raised → requester 2 granted.
- **Withdrawal.** `req[1]` pulses for 3 cycles while `busy` → no `ack[1]`; the next frame is not for requester 1.
- **Reset mid-frame.** `reset = 0` during `DATA` bit 4 → `tx = 1`, `busy = 0` the next cycle, no `tx_done`; a fresh request afterwards is granted to requester 0.
- **Real baud rate.** Drive `tick` from a 651-count generator and send 8'h55 → each bit lasts 10416 ± 1 clocks.
